wb_stage: RTL and testbench

Writeback stage of the pipelined RV32I core: the MEM/WB pipeline register plus load-data extraction and result selection. It drives the register-file write port (`we3`/`a3`/`wd3`), which commits on the falling clock edge, and it keeps a retired-instruction counter. All outputs are flop outputs, so the full first half-cycle is available before the register file's negedge write.

---
 rtl/wb_stage.sv | 136 +++++++++++++
 tb/tb_wb_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data extraction, result select
// and retired-instruction counter. Every output comes straight from a flop.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_w,
  input  logic            flush_w,
  input  logic            valid_m,
  input  logic            regwrite_m,
  input  logic [1:0]      resultsrc_m,
  input  logic [2:0]      funct3_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [XLEN-1:0] readdata_m,
  input  logic [XLEN-1:0] pcplus4_m,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic            valid_w,
  output logic            misalign_w,
  output logic [31:0]     retire_cnt
);

  localparam int unsigned CNT_W = 32;
  localparam logic [1:0]  RES_LOAD = 2'b01;
  localparam logic [1:0]  RES_PC4  = 2'b10;

  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic            load_misalign;
  logic            misalign;
  logic [XLEN-1:0] result;

  logic            we3_q, we3_d;
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign off = aluresult_m[1:0];

  // Lane selection and width/sign handling for loads
  always_comb begin
    byte_sel      = readdata_m[7:0];
    half_sel      = off[1] ? readdata_m[31:16] : readdata_m[15:0];
    load_data     = readdata_m;
    load_misalign = 1'b0;
    case (off)
      2'd0:    byte_sel = readdata_m[7:0];
      2'd1:    byte_sel = readdata_m[15:8];
      2'd2:    byte_sel = readdata_m[23:16];
      default: byte_sel = readdata_m[31:24];
    endcase
    case (funct3_m)
      3'b000: load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100: load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001: begin
        load_data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        load_misalign = off[0];
      end
      3'b101: begin
        load_data     = {{(XLEN-16){1'b0}}, half_sel};
        load_misalign = off[0];
      end
      default: begin
        load_data     = readdata_m;
        load_misalign = (off != 2'b00);
      end
    endcase
  end

  always_comb begin
    result   = aluresult_m;
    misalign = valid_m && (resultsrc_m == RES_LOAD) && load_misalign;
    case (resultsrc_m)
      RES_LOAD: result = load_data;
      RES_PC4:  result = pcplus4_m;
      default:  result = aluresult_m;
    endcase
  end

  // Update priority: flush, then stall (hold), then capture
  always_comb begin
    we3_d        = we3_q;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    valid_d      = valid_q;
    misalign_d   = misalign_q;
    retire_cnt_d = retire_cnt_q;
    if (flush_w) begin
      we3_d      = 1'b0;
      a3_d       = 5'd0;
      wd3_d      = '0;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (!stall_w) begin
      we3_d        = valid_m && regwrite_m && (rd_m != 5'd0) && !misalign;
      a3_d         = rd_m;
      wd3_d        = result;
      valid_d      = valid_m;
      misalign_d   = misalign;
      retire_cnt_d = retire_cnt_q + CNT_W'(valid_m);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_q        <= 1'b0;
      a3_q         <= 5'd0;
      wd3_q        <= '0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign we3        = we3_q;
  assign a3         = a3_q;
  assign wd3        = wd3_q;
  assign valid_w    = valid_q;
  assign misalign_w = misalign_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations and a
// negedge-write register file model for write-through checks.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_w;
  logic        flush_w;
  logic        valid_m;
  logic        regwrite_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] aluresult_m;
  logic [31:0] readdata_m;
  logic [31:0] pcplus4_m;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        valid_w;
  logic        misalign_w;
  logic [31:0] retire_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] rf [32];

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
    .readdata_m(readdata_m), .pcplus4_m(pcplus4_m),
    .we3(we3), .a3(a3), .wd3(wd3), .valid_w(valid_w),
    .misalign_w(misalign_w), .retire_cnt(retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file commits on the falling edge
  always @(negedge clk) begin
    if (we3) rf[a3] <= wd3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m = v; regwrite_m = rw; resultsrc_m = rs; funct3_m = f3;
    rd_m = rd; aluresult_m = alu; readdata_m = rdata; pcplus4_m = pc4;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input logic e_we, input logic [4:0] e_a3,
                         input logic [31:0] e_wd, input logic e_mis);
    check({tag, ".we3"}, 32'(we3), 32'(e_we));
    check({tag, ".a3"}, 32'(a3), 32'(e_a3));
    check({tag, ".wd3"}, wd3, e_wd);
    check({tag, ".mis"}, 32'(misalign_w), 32'(e_mis));
    check({tag, ".cnt"}, retire_cnt, exp_cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    #1 rst = 1'b1;
    cycle();
    check("rst.we3", 32'(we3), 32'd0);
    check("rst.a3", 32'(a3), 32'd0);
    check("rst.wd3", wd3, 32'd0);
    check("rst.valid", 32'(valid_w), 32'd0);
    check("rst.mis", 32'(misalign_w), 32'd0);
    check("rst.cnt", retire_cnt, 32'd0);
    rst = 1'b0;

    // 1: asynchronous reset while a write is pending
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h55, 32'd0, 32'd0);
    cycle();
    exp_cnt = 32'd1;
    check_w("t1.pre", 1'b1, 5'd5, 32'h55, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 32'd0;
    check_w("t1.async", 1'b0, 5'd0, 32'd0, 1'b0);
    check("t1.async.valid", 32'(valid_w), 32'd0);
    rst = 1'b0;

    // 2: byte loads
    drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd2, 32'h1001, 32'h8070F0FF, 32'd0);
    cycle(); exp_cnt++;
    check_w("t2.lb1", 1'b1, 5'd2, 32'hFFFFFFF0, 1'b0);
    check("t2.lb1.valid", 32'(valid_w), 32'd1);
    drive(1'b1, 1'b1, 2'b01, 3'b100, 5'd2, 32'h1003, 32'h8070F0FF, 32'd0);
    cycle(); exp_cnt++;
    check_w("t2.lbu3", 1'b1, 5'd2, 32'h00000080, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd4, 32'h1002, 32'h8070F0FF, 32'd0);
    cycle(); exp_cnt++;
    check_w("t2.lb2", 1'b1, 5'd4, 32'h00000070, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 3'b100, 5'd4, 32'h1000, 32'h8070F0FF, 32'd0);
    cycle(); exp_cnt++;
    check_w("t2.lbu0", 1'b1, 5'd4, 32'h000000FF, 1'b0);

    // 3: halfword / word loads and misalignment
    drive(1'b1, 1'b1, 2'b01, 3'b001, 5'd6, 32'h2002, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check_w("t3.lh2", 1'b1, 5'd6, 32'hFFFF8001, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 3'b101, 5'd6, 32'h2000, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check_w("t3.lhu0", 1'b1, 5'd6, 32'h00001234, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 3'b101, 5'd6, 32'h2001, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check("t3.lhu1.we3", 32'(we3), 32'd0);
    check("t3.lhu1.mis", 32'(misalign_w), 32'd1);
    check("t3.lhu1.cnt", retire_cnt, exp_cnt);
    // misaligned instruction held by a stall keeps its flag
    stall_w = 1'b1;
    cycle();
    check("t3.stall.mis", 32'(misalign_w), 32'd1);
    stall_w = 1'b0;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd6, 32'h2002, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check("t3.lw2.we3", 32'(we3), 32'd0);
    check("t3.lw2.mis", 32'(misalign_w), 32'd1);
    drive(1'b1, 1'b1, 2'b01, 3'b011, 5'd6, 32'h2000, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check_w("t3.f3_011", 1'b1, 5'd6, 32'h80011234, 1'b0);
    // odd address with ALU result select is not a load
    drive(1'b1, 1'b1, 2'b00, 3'b010, 5'd8, 32'h2003, 32'h80011234, 32'd0);
    cycle(); exp_cnt++;
    check_w("t3.alu_odd", 1'b1, 5'd8, 32'h2003, 1'b0);

    // 4: x0 target, JAL, select 11, invalid capture
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 32'h1234, 32'd0, 32'd0);
    cycle(); exp_cnt++;
    check_w("t4.x0", 1'b0, 5'd0, 32'h1234, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'h9999, 32'd0, 32'h104);
    cycle(); exp_cnt++;
    check_w("t4.jal", 1'b1, 5'd1, 32'h104, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 3'b000, 5'd9, 32'hA5A5, 32'h1, 32'h2);
    cycle(); exp_cnt++;
    check_w("t4.sel11", 1'b1, 5'd9, 32'hA5A5, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 3'b000, 5'd9, 32'h7777, 32'd0, 32'd0);
    cycle();
    check_w("t4.inv", 1'b0, 5'd9, 32'h7777, 1'b0);
    check("t4.inv.valid", 32'(valid_w), 32'd0);

    // 5: stall for three cycles, then flush with stall
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'hDEADBEEF, 32'd0, 32'd0);
    cycle(); exp_cnt++;
    check_w("t5.cap", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b10, 3'b000, 5'(10 + i), 32'h1111 * (i + 1), 32'd0, 32'h40);
      cycle();
      check_w($sformatf("t5.stall%0d", i), 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
      check($sformatf("t5.stall%0d.valid", i), 32'(valid_w), 32'd1);
    end
    flush_w = 1'b1;
    cycle();
    check_w("t5.flush", 1'b0, 5'd0, 32'd0, 1'b0);
    check("t5.flush.valid", 32'(valid_w), 32'd0);
    flush_w = 1'b0; stall_w = 1'b0;

    // 6: back-to-back writes to x3, read after each negedge
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h00000011, 32'd0, 32'd0);
    cycle(); exp_cnt++;
    check_w("t6.add", 1'b1, 5'd3, 32'h11, 1'b0);
    @(negedge clk); #1;
    check("t6.rf_add", rf[3], 32'h11);
    drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd3, 32'h3000, 32'hCAFEBABE, 32'd0);
    cycle(); exp_cnt++;
    check_w("t6.lw", 1'b1, 5'd3, 32'hCAFEBABE, 1'b0);
    @(negedge clk); #1;
    check("t6.rf_lw", rf[3], 32'hCAFEBABE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
